// File: rtl/timer_pkg.sv
// Shared constants and types for the timer APB sequencer.
// Register map, TCR/TSR bit positions, the APB request payload,
// the sequencer state encoding and small helpers that build register values.
package timer_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // Timer register map
  localparam logic [ADDR_W-1:0] TCR_ADDR = 8'h00;
  localparam logic [ADDR_W-1:0] TDR_ADDR = 8'h01;
  localparam logic [ADDR_W-1:0] TSR_ADDR = 8'h02;

  // TCR bit positions
  localparam int unsigned TCR_LOAD_BIT    = 7;
  localparam int unsigned TCR_DW_BIT      = 5;
  localparam int unsigned TCR_EN_BIT      = 4;
  localparam int unsigned TCR_CLK_SEL_MSB = 1;
  localparam int unsigned TCR_CLK_SEL_LSB = 0;

  // TSR bit positions
  localparam int unsigned TSR_OVF_BIT = 0;

  localparam logic [DATA_W-1:0] TCR_STOP_VAL = 8'h00;
  localparam logic [DATA_W-1:0] TSR_CLR_VAL  = 8'h00;

  // One APB transfer request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } apb_req_t;

  typedef enum logic [3:0] {
    IDLE,
    WR_TDR,
    WR_LOAD,
    WR_EN,
    GAP,
    RD_TSR,
    WR_CLR,
    WR_STOP,
    DONE
  } state_t;

  function automatic apb_req_t mk_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    apb_req_t r;
    r.addr  = a;
    r.wdata = d;
    r.write = 1'b1;
    return r;
  endfunction

  function automatic apb_req_t mk_rd(input logic [ADDR_W-1:0] a);
    apb_req_t r;
    r.addr  = a;
    r.wdata = '0;
    r.write = 1'b0;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] tcr_load();
    logic [DATA_W-1:0] v;
    v = '0;
    v[TCR_LOAD_BIT] = 1'b1;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] tcr_enable(input logic dw, input logic [1:0] cs);
    logic [DATA_W-1:0] v;
    v = '0;
    v[TCR_EN_BIT] = 1'b1;
    v[TCR_DW_BIT] = dw;
    v[TCR_CLK_SEL_MSB:TCR_CLK_SEL_LSB] = cs;
    return v;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Two-phase APB master handshake engine.
// Ports: pclk/presetn; req/addr/wdata/write request a transfer (accepted when
// idle or in the completing ACCESS cycle, giving back-to-back SETUPs);
// ack/rdata/slverr report the completing cycle combinationally;
// psel/penable/pwrite/paddr/pwdata (registered) and prdata/pready/pslverr
// form the APB bus.
module apb_master_xfer
  import timer_pkg::*;
(
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              slverr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  // Completion is the ACCESS cycle in which the slave is ready
  assign ack    = psel_q & penable_q & pready;
  assign rdata  = ack ? prdata : '0;
  assign slverr = ack & pslverr;

  // Phase sequencing: idle/complete -> SETUP on req, SETUP -> ACCESS, hold ACCESS until ready
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (!psel_q || ack) begin
      if (req) begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = write;
        paddr_d   = addr;
        pwdata_d  = wdata;
      end else begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: rtl/timer_apb_seq.sv
// Timer programming sequencer: on start, loads and enables a timer over APB,
// polls TSR for overflows (clearing each one) until the requested number of
// periods has elapsed, then stops the timer. Supports abort, slave-error and
// poll-timeout termination, all of which still issue the stop write.
// Ports: pclk/presetn; start/abort control; init_val/dw/clk_sel/periods
// configuration; busy/done/err/ovf_cnt status; APB master bus.
module timer_apb_seq
  import timer_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 1000
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] init_val,
  input  logic              dw,
  input  logic [1:0]        clk_sel,
  input  logic [7:0]        periods,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        ovf_cnt,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [PW-1:0] POLL_LAST = PW'((MAX_POLLS > 0) ? MAX_POLLS - 1 : 0);

  state_t            state_q, state_d;
  logic              rst_done_q;
  logic [DATA_W-1:0] init_q, init_d;
  logic              dw_q, dw_d;
  logic [1:0]        cs_q, cs_d;
  logic [7:0]        periods_q, periods_d;
  logic [7:0]        ovf_cnt_q, ovf_cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              abort_pend_q, abort_pend_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]     poll_cnt_q, poll_cnt_d;

  logic              req_c;
  apb_req_t          req_pl_c;
  logic              abort_now_c;
  logic              go_stop_c;
  logic              go_poll_c;
  logic              x_ack;
  logic [DATA_W-1:0] x_rdata;
  logic              x_slverr;
  logic              rdata_unused_c;

  apb_master_xfer u_xfer (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (req_c),
    .addr    (req_pl_c.addr),
    .wdata   (req_pl_c.wdata),
    .write   (req_pl_c.write),
    .ack     (x_ack),
    .rdata   (x_rdata),
    .slverr  (x_slverr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  // Only the overflow flag of TSR matters
  assign rdata_unused_c = ^x_rdata;

  // Next-state, request and status logic
  always_comb begin
    state_d      = state_q;
    init_d       = init_q;
    dw_d         = dw_q;
    cs_d         = cs_q;
    periods_d    = periods_q;
    ovf_cnt_d    = ovf_cnt_q;
    err_d        = err_q;
    abort_pend_d = abort_pend_q;
    gap_cnt_d    = gap_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    req_c        = 1'b0;
    req_pl_c     = mk_rd(TSR_ADDR);
    go_stop_c    = 1'b0;
    go_poll_c    = 1'b0;

    // Abort is remembered until the next transfer boundary
    if (busy_q && abort) abort_pend_d = 1'b1;
    abort_now_c = abort_pend_q | abort;

    unique case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        // rst_done_q keeps the first post-reset edge free of transfers
        if (start && rst_done_q) begin
          init_d     = init_val;
          dw_d       = dw;
          cs_d       = clk_sel;
          periods_d  = (periods == 8'd0) ? 8'd1 : periods;
          ovf_cnt_d  = '0;
          err_d      = 1'b0;
          poll_cnt_d = '0;
          state_d    = WR_TDR;
          req_c      = 1'b1;
          req_pl_c   = mk_wr(TDR_ADDR, init_val);
        end
      end
      WR_TDR: begin
        if (x_ack) begin
          if (x_slverr || abort_now_c) begin
            err_d     = 1'b1;
            go_stop_c = 1'b1;
          end else begin
            state_d  = WR_LOAD;
            req_c    = 1'b1;
            req_pl_c = mk_wr(TCR_ADDR, tcr_load());
          end
        end
      end
      WR_LOAD: begin
        if (x_ack) begin
          if (x_slverr || abort_now_c) begin
            err_d     = 1'b1;
            go_stop_c = 1'b1;
          end else begin
            state_d  = WR_EN;
            req_c    = 1'b1;
            req_pl_c = mk_wr(TCR_ADDR, tcr_enable(dw_q, cs_q));
          end
        end
      end
      WR_EN: begin
        if (x_ack) begin
          if (x_slverr || abort_now_c) begin
            err_d     = 1'b1;
            go_stop_c = 1'b1;
          end else begin
            go_poll_c = 1'b1;
          end
        end
      end
      GAP: begin
        // No transfer is in flight here, so abort acts immediately
        if (abort_now_c) begin
          err_d     = 1'b1;
          go_stop_c = 1'b1;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d  = RD_TSR;
          req_c    = 1'b1;
          req_pl_c = mk_rd(TSR_ADDR);
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      RD_TSR: begin
        if (x_ack) begin
          if (x_slverr) begin
            err_d     = 1'b1;
            go_stop_c = 1'b1;
          end else if (x_rdata[TSR_OVF_BIT]) begin
            // Overflow is always cleared first, even if abort is pending
            ovf_cnt_d  = (ovf_cnt_q == 8'hFF) ? ovf_cnt_q : ovf_cnt_q + 8'd1;
            poll_cnt_d = '0;
            state_d    = WR_CLR;
            req_c      = 1'b1;
            req_pl_c   = mk_wr(TSR_ADDR, TSR_CLR_VAL);
          end else if (poll_cnt_q == POLL_LAST || abort_now_c) begin
            err_d     = 1'b1;
            go_stop_c = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
            go_poll_c  = 1'b1;
          end
        end
      end
      WR_CLR: begin
        if (x_ack) begin
          if (x_slverr || abort_now_c) begin
            err_d     = 1'b1;
            go_stop_c = 1'b1;
          end else if (ovf_cnt_q >= periods_q) begin
            go_stop_c = 1'b1;
          end else begin
            go_poll_c = 1'b1;
          end
        end
      end
      WR_STOP: begin
        // A slave error on the stop write does not change err
        if (x_ack) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_poll_c) begin
      if (POLL_GAP == 0) begin
        state_d  = RD_TSR;
        req_c    = 1'b1;
        req_pl_c = mk_rd(TSR_ADDR);
      end else begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
    end

    if (go_stop_c) begin
      state_d      = WR_STOP;
      req_c        = 1'b1;
      req_pl_c     = mk_wr(TCR_ADDR, TCR_STOP_VAL);
      abort_pend_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      rst_done_q   <= 1'b0;
      init_q       <= '0;
      dw_q         <= 1'b0;
      cs_q         <= '0;
      periods_q    <= '0;
      ovf_cnt_q    <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      gap_cnt_q    <= '0;
      poll_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rst_done_q   <= 1'b1;
      init_q       <= init_d;
      dw_q         <= dw_d;
      cs_q         <= cs_d;
      periods_q    <= periods_d;
      ovf_cnt_q    <= ovf_cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      abort_pend_q <= abort_pend_d;
      gap_cnt_q    <= gap_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_timer_apb_seq.sv
// Bench for timer_apb_seq: a behavioural APB timer slave logs every completed
// transfer; a table of vectors with hand-computed expectations is run in a
// loop, followed by hand-written abort, start-while-busy and reset sequences.
module tb_timer_apb_seq;
  import timer_pkg::*;

  localparam int unsigned POLL_GAP  = 2;
  localparam int unsigned MAX_POLLS = 5;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       start, abort;
  logic [7:0] init_val;
  logic       dw;
  logic [1:0] clk_sel;
  logic [7:0] periods;
  logic       busy, done, err;
  logic [7:0] ovf_cnt;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;

  timer_apb_seq #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .pclk(pclk), .presetn(presetn), .start(start), .abort(abort),
    .init_val(init_val), .dw(dw), .clk_sel(clk_sel), .periods(periods),
    .busy(busy), .done(done), .err(err), .ovf_cnt(ovf_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // ---------------- slave model ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       write;
    int         acc;
  } xlog_t;

  xlog_t      xlog[$];
  int         cfg_ovf_every, cfg_err_idx, cfg_delay_idx, cfg_delay_cyc;
  bit         clr_req = 1'b0;
  int         wait_cnt, rd_since, xfer_idx, stab_err, cur_acc;
  logic [7:0] s_addr, s_wdata;
  logic       s_write;

  always @(negedge pclk) begin
    if (clr_req) begin
      xlog.delete();
      wait_cnt = 0; rd_since = 0; xfer_idx = 0; stab_err = 0; cur_acc = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = 8'hA4;
    end else if (psel && !penable) begin
      s_addr = paddr; s_wdata = pwdata; s_write = pwrite;
      wait_cnt = 0; cur_acc = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = 8'hA4;
    end else if (psel && penable) begin
      cur_acc++;
      if (paddr !== s_addr || pwdata !== s_wdata || pwrite !== s_write) stab_err++;
      if (xfer_idx == cfg_delay_idx && wait_cnt < cfg_delay_cyc) begin
        wait_cnt++;
        pready = 1'b0;
      end else begin
        pready  = 1'b1;
        pslverr = (xfer_idx == cfg_err_idx);
        prdata  = 8'hA4;
        if (!pwrite && paddr == TSR_ADDR) begin
          if (cfg_ovf_every != 0 && rd_since + 1 == cfg_ovf_every) begin
            prdata   = 8'hA5;
            rd_since = 0;
          end else begin
            rd_since++;
          end
        end
        xlog.push_back('{addr: paddr, wdata: pwdata, write: pwrite, acc: cur_acc});
        xfer_idx++;
      end
    end else begin
      pready = 1'b0; pslverr = 1'b0; prdata = 8'hA4;
    end
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int enc(input logic w, input logic [7:0] a, input logic [7:0] d);
    return int'({w, a, d});
  endfunction

  typedef struct {
    logic [7:0] init_val;
    logic       dw;
    logic [1:0] clk_sel;
    logic [7:0] periods;
    int         ovf_every;
    int         err_idx;
    int         delay_idx;
    int         delay_cyc;
    int         exp_xfers;
    int         exp_reads;
    int         exp_clears;
    logic [7:0] exp_en;
    int         exp_ovf;
    logic       exp_err;
    int         exp_acc0;
  } vec_t;

  vec_t vecs[9];

  task automatic clr_slave();
    clr_req = 1'b1;
    @(negedge pclk);
    #1 clr_req = 1'b0;
  endtask

  task automatic set_cfg(input int ovf_every, input int err_idx, input int d_idx, input int d_cyc);
    cfg_ovf_every = ovf_every;
    cfg_err_idx   = err_idx;
    cfg_delay_idx = d_idx;
    cfg_delay_cyc = d_cyc;
  endtask

  task automatic pulse_start();
    @(negedge pclk) start = 1'b1;
    @(negedge pclk) start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge pclk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_tsr(output int reads, output int clears);
    reads = 0; clears = 0;
    foreach (xlog[k]) begin
      if (!xlog[k].write && xlog[k].addr == TSR_ADDR) reads++;
      if (xlog[k].write && xlog[k].addr == TSR_ADDR && xlog[k].wdata == 8'h00) clears++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit    got;
    int    n, rd, cl;
    string t;
    t = $sformatf("v%0d", id);
    set_cfg(v.ovf_every, v.err_idx, v.delay_idx, v.delay_cyc);
    clr_slave();
    init_val = v.init_val; dw = v.dw; clk_sel = v.clk_sel; periods = v.periods;
    pulse_start();
    chk({t, "_first_setup"}, int'({psel, penable, paddr}), int'({1'b1, 1'b0, TDR_ADDR}));
    chk({t, "_busy_start"}, int'(busy), 1);
    wait_done(got);
    chk({t, "_done_seen"}, int'(got), 1);
    chk({t, "_err"}, int'(err), int'(v.exp_err));
    chk({t, "_ovf_cnt"}, int'(ovf_cnt), v.exp_ovf);
    chk({t, "_busy_done"}, int'(busy), 1);
    @(negedge pclk);
    chk({t, "_idle_after"}, int'({busy, done}), 0);
    repeat (3) @(negedge pclk);
    chk({t, "_err_hold"}, int'({err, ovf_cnt}), int'({v.exp_err, 8'(v.exp_ovf)}));
    n = xlog.size();
    chk({t, "_xfers"}, n, v.exp_xfers);
    if (n >= 1) chk({t, "_tdr"}, enc(xlog[0].write, xlog[0].addr, xlog[0].wdata), enc(1'b1, TDR_ADDR, v.init_val));
    if (n >= 1) chk({t, "_acc0"}, xlog[0].acc, v.exp_acc0);
    if (n >= 2) chk({t, "_load"}, enc(xlog[1].write, xlog[1].addr, xlog[1].wdata), enc(1'b1, TCR_ADDR, 8'h80));
    if (n >= 3) chk({t, "_enable"}, enc(xlog[2].write, xlog[2].addr, xlog[2].wdata), enc(1'b1, TCR_ADDR, v.exp_en));
    if (n >= 1) chk({t, "_stop"}, enc(xlog[n-1].write, xlog[n-1].addr, xlog[n-1].wdata), enc(1'b1, TCR_ADDR, 8'h00));
    count_tsr(rd, cl);
    chk({t, "_reads"}, rd, v.exp_reads);
    chk({t, "_clears"}, cl, v.exp_clears);
    chk({t, "_stable"}, stab_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int n, psel_cnt;

    //            init   dw    cs    per  ovf err dly cyc xf rd cl en     ovf err  acc0
    vecs[0] = '{8'hC8, 1'b0, 2'd0, 8'd1, 3, -1, -1, 0,  8, 3, 1, 8'h10, 1, 1'b0, 1};
    vecs[1] = '{8'h5A, 1'b1, 2'd2, 8'd3, 2, -1, -1, 0, 13, 6, 3, 8'h32, 3, 1'b0, 1};
    vecs[2] = '{8'h11, 1'b0, 2'd0, 8'd1, 3, -1,  0, 3,  8, 3, 1, 8'h10, 1, 1'b0, 4};
    vecs[3] = '{8'h3C, 1'b0, 2'd3, 8'd0, 1, -1, -1, 0,  6, 1, 1, 8'h13, 1, 1'b0, 1};
    vecs[4] = '{8'h77, 1'b0, 2'd1, 8'd1, 3,  2, -1, 0,  4, 0, 0, 8'h11, 0, 1'b1, 1};
    vecs[5] = '{8'h20, 1'b1, 2'd0, 8'd1, 0, -1, -1, 0,  9, 5, 0, 8'h30, 0, 1'b1, 1};
    vecs[6] = '{8'h9F, 1'b0, 2'd0, 8'd1, 1,  5, -1, 0,  6, 1, 1, 8'h10, 1, 1'b0, 1};
    vecs[7] = '{8'h42, 1'b1, 2'd1, 8'd2, 1,  3, -1, 0,  5, 1, 0, 8'h31, 0, 1'b1, 1};
    vecs[8] = '{8'hE0, 1'b1, 2'd3, 8'd2, 1, -1, -1, 0,  8, 2, 2, 8'h33, 2, 1'b0, 1};

    presetn = 1'b0; start = 1'b0; abort = 1'b0;
    init_val = 8'h00; dw = 1'b0; clk_sel = 2'd0; periods = 8'd1;
    set_cfg(0, -1, -1, 0);
    #2;
    chk("reset_bus", int'({psel, penable, pwrite, paddr, pwdata}), 0);
    chk("reset_status", int'({busy, done, err, ovf_cnt}), 0);
    #21 presetn = 1'b1;
    clr_slave();
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      repeat (2) @(negedge pclk);
    end

    // Abort during the load write's ACCESS phase
    set_cfg(3, -1, 1, 2);
    clr_slave();
    init_val = 8'hC8; dw = 1'b0; clk_sel = 2'd0; periods = 8'd1;
    pulse_start();
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (psel && penable && paddr == TCR_ADDR && pwdata == 8'h80) begin
        got = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    chk("abort_load_access_seen", int'(got), 1);
    abort = 1'b1;
    @(negedge pclk) abort = 1'b0;
    wait_done(got);
    chk("abort_done_seen", int'(got), 1);
    chk("abort_err", int'({err, ovf_cnt}), int'({1'b1, 8'h00}));
    n = xlog.size();
    chk("abort_xfers", n, 3);
    if (n == 3) begin
      chk("abort_load", enc(xlog[1].write, xlog[1].addr, xlog[1].wdata), enc(1'b1, TCR_ADDR, 8'h80));
      chk("abort_stop", enc(xlog[2].write, xlog[2].addr, xlog[2].wdata), enc(1'b1, TCR_ADDR, 8'h00));
    end
    repeat (2) @(negedge pclk);

    // Start while busy is ignored
    set_cfg(3, -1, -1, 0);
    clr_slave();
    init_val = 8'hC8;
    pulse_start();
    repeat (6) @(negedge pclk);
    init_val = 8'h55;
    start = 1'b1;
    @(negedge pclk) start = 1'b0;
    wait_done(got);
    chk("busy_start_done", int'(got), 1);
    chk("busy_start_xfers", xlog.size(), 8);
    if (xlog.size() >= 1) chk("busy_start_tdr", int'(xlog[0].wdata), 8'hC8);
    psel_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      if (psel) psel_cnt++;
    end
    chk("busy_start_no_rerun", psel_cnt, 0);
    chk("busy_start_idle", int'(busy), 0);

    // Reset in the middle of ACCESS, then start held across reset release
    set_cfg(1, -1, 0, 6);
    clr_slave();
    init_val = 8'hE1; dw = 1'b0; clk_sel = 2'd0; periods = 8'd1;
    pulse_start();
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (penable) begin
        got = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    chk("rst_access_seen", int'(got), 1);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_bus", int'({psel, penable, pwrite, paddr, pwdata}), 0);
    chk("rst_mid_status", int'({busy, done, err, ovf_cnt}), 0);
    start = 1'b1;
    @(negedge pclk);
    #2 presetn = 1'b1;
    @(negedge pclk);
    chk("rst_release_no_xfer", int'({psel, busy}), 0);
    @(negedge pclk);
    chk("rst_release_start", int'({psel, penable, paddr}), int'({1'b1, 1'b0, TDR_ADDR}));
    start = 1'b0;
    wait_done(got);
    chk("rst_rerun_done", int'(got), 1);
    chk("rst_rerun_status", int'({err, ovf_cnt}), int'({1'b0, 8'h01}));
    chk("rst_rerun_xfers", xlog.size(), 6);
    if (xlog.size() >= 1) chk("rst_rerun_acc0", xlog[0].acc, 7);

    repeat (2) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
